store_buffer: RTL

- FIFO store buffer between the EX/MEM pipeline register and the byte-addressed data memory (8-bit address, asynchronous read, synchronous write, one shared address port).
- Retires stores into a queue so the pipeline does not wait on the memory write.
- Drains queued stores to memory in idle port cycles.
- Serves loads directly from memory, or forwards data from a queued store. Stalls the pipeline on partial overlaps, buffer full, or fence.

---
 rtl/mem_pkg.sv | 59 +++++
 rtl/store_buffer_if.sv | 24 ++
 rtl/store_fwd_check.sv | 42 ++++
 rtl/store_buffer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - load/store type encodings, access sizes and byte-span overlap helpers
package mem_pkg;

    localparam logic [1:0] STORE_SB = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SW = 2'b10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LBU = 3'b001;
    localparam logic [2:0] LOAD_LH  = 3'b010;
    localparam logic [2:0] LOAD_LHU = 3'b011;
    localparam logic [2:0] LOAD_LW  = 3'b100;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FENCE = 1'b1
    } sb_state_e;

    // Unused type codes fall through to word size.
    function automatic logic [2:0] store_size(input logic [1:0] t);
        case (t)
            STORE_SB: return 3'd1;
            STORE_SH: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] load_size(input logic [2:0] t);
        case (t)
            LOAD_LB, LOAD_LBU: return 3'd1;
            LOAD_LH, LOAD_LHU: return 3'd2;
            default:           return 3'd4;
        endcase
    endfunction

    // Spans wrap mod 2^aw; they overlap iff either start lies inside the other span.
    function automatic logic spans_overlap(input logic [31:0] a, input logic [2:0] a_size,
                                           input logic [31:0] b, input logic [2:0] b_size,
                                           input int aw);
        logic [31:0] mask;
        logic [31:0] d_ab;
        logic [31:0] d_ba;
        mask = (32'd1 << aw) - 32'd1;
        d_ab = (b - a) & mask;
        d_ba = (a - b) & mask;
        return (d_ab < {29'd0, a_size}) || (d_ba < {29'd0, b_size});
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [2:0] t);
        case (t)
            LOAD_LB:  return {{24{d[7]}}, d[7:0]};
            LOAD_LBU: return {24'd0, d[7:0]};
            LOAD_LH:  return {{16{d[15]}}, d[15:0]};
            LOAD_LHU: return {16'd0, d[15:0]};
            default:  return d;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - data memory port between the store buffer (master) and memory (slave)
interface store_buffer_if #(
    parameter int AW = 8
);
    logic          mem_rd_en_o;
    logic          mem_wr_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wr_data_o;
    logic [2:0]    mem_load_type_o;
    logic [1:0]    mem_store_type_o;
    logic [31:0]   mem_rd_data_i;

    modport master (
        output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o,
               mem_load_type_o, mem_store_type_o,
        input  mem_rd_data_i
    );

    modport slave (
        input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o,
               mem_load_type_o, mem_store_type_o,
        output mem_rd_data_i
    );
endinterface

// File: rtl/store_fwd_check.sv
// rtl/store_fwd_check.sv - finds the youngest queued store overlapping a load and classifies it
module store_fwd_check
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [DEPTH-1:0][AW-1:0] addr_i,
    input  logic [DEPTH-1:0][1:0]    type_i,
    input  logic [IW-1:0]            head_i,
    input  logic [AW-1:0]            ld_addr_i,
    input  logic [2:0]               ld_type_i,
    output logic                     hit_o,
    output logic                     partial_o,
    output logic [IW-1:0]            idx_o
);

    logic          any_overlap;
    logic [IW-1:0] slot;

    // Walk oldest to youngest so the last match left in idx_o is the youngest.
    always_comb begin
        any_overlap = 1'b0;
        idx_o       = '0;
        slot        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + IW'(k);
            if (valid_i[slot] &&
                spans_overlap(32'(addr_i[slot]), store_size(type_i[slot]),
                              32'(ld_addr_i), load_size(ld_type_i), AW)) begin
                any_overlap = 1'b1;
                idx_o       = slot;
            end
        end
        hit_o     = any_overlap && (addr_i[idx_o] == ld_addr_i) &&
                    (store_size(type_i[idx_o]) >= load_size(ld_type_i));
        partial_o = any_overlap && !hit_o;
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO store buffer with load forwarding, idle-cycle drain and fence
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    input  logic          req_is_store_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wr_data_i,
    input  logic [1:0]    store_type_i,
    input  logic [2:0]    load_type_i,
    input  logic          fence_i,
    output logic          ready_o,
    output logic [31:0]   load_data_o,
    output logic          empty_o,
    store_buffer_if.master mem
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    sb_state_e                state_q, state_d;
    logic [IW-1:0]            head_q, head_d;
    logic [IW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0] ent_addr_q, ent_addr_d;
    logic [DEPTH-1:0][31:0]   ent_data_q, ent_data_d;
    logic [DEPTH-1:0][1:0]    ent_type_q, ent_type_d;

    logic          fwd_hit;
    logic          fwd_partial;
    logic [IW-1:0] fwd_idx;
    logic          fence_active;
    logic          load_port;
    logic          enq;
    logic          deq;

    store_fwd_check #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd (
        .valid_i   (valid_q),
        .addr_i    (ent_addr_q),
        .type_i    (ent_type_q),
        .head_i    (head_q),
        .ld_addr_i (addr_i),
        .ld_type_i (load_type_i),
        .hit_o     (fwd_hit),
        .partial_o (fwd_partial),
        .idx_o     (fwd_idx)
    );

    assign empty_o = (count_q == '0);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_type_d = ent_type_q;

        ready_o              = 1'b1;
        load_data_o          = '0;
        mem.mem_rd_en_o      = 1'b0;
        mem.mem_wr_en_o      = 1'b0;
        mem.mem_addr_o       = '0;
        mem.mem_wr_data_o    = '0;
        mem.mem_load_type_o  = '0;
        mem.mem_store_type_o = '0;

        load_port = 1'b0;
        enq       = 1'b0;
        deq       = 1'b0;

        // A fence blocks the pipeline already in the cycle it is raised.
        fence_active = (state_q == ST_FENCE) || (fence_i && (count_q != '0));

        if (fence_active) begin
            ready_o = 1'b0;
        end else if (req_valid_i) begin
            if (req_is_store_i) begin
                ready_o = (count_q < CW'(DEPTH));
                enq     = ready_o;
            end else if (fwd_hit) begin
                load_data_o = load_extend(ent_data_q[fwd_idx], load_type_i);
            end else if (fwd_partial) begin
                ready_o = 1'b0;
            end else begin
                load_port           = 1'b1;
                mem.mem_rd_en_o     = 1'b1;
                mem.mem_addr_o      = addr_i;
                mem.mem_load_type_o = load_type_i;
                load_data_o         = mem.mem_rd_data_i;
            end
        end

        if (!rst && (count_q != '0) && !load_port) begin
            deq                  = 1'b1;
            mem.mem_wr_en_o      = 1'b1;
            mem.mem_addr_o       = ent_addr_q[head_q];
            mem.mem_wr_data_o    = ent_data_q[head_q];
            mem.mem_store_type_o = ent_type_q[head_q];
        end

        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IW'(1);
        end
        if (enq) begin
            valid_d[tail_q]    = 1'b1;
            ent_addr_d[tail_q] = addr_i;
            ent_data_d[tail_q] = wr_data_i;
            ent_type_d[tail_q] = store_type_i;
            tail_d             = tail_q + IW'(1);
        end
        count_d = count_q + CW'(enq) - CW'(deq);
        state_d = (fence_active && (count_d != '0)) ? ST_FENCE : ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: valid_q alone says whether a slot means anything.
    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_type_q <= ent_type_d;
    end

endmodule
